// File: rtl/sdram_req_arbiter.sv
// Arbitrates N application masters onto the single sdrc_core request port and
// routes the controller's data handshakes back to the channel that owns the burst.
module sdram_req_arbiter #(
  parameter int NCH   = 4,
  parameter int AW    = 25,
  parameter int LW    = 9,
  parameter int GUARD = 2,
  parameter int RR    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_wr_n,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*LW-1:0] ch_len,
  output logic [NCH-1:0]    ch_ack,
  output logic [NCH-1:0]    ch_rd_valid,
  output logic [NCH-1:0]    ch_wr_next,
  output logic              app_req,
  output logic [AW-1:0]     app_req_addr,
  output logic [LW-1:0]     app_req_len,
  output logic              app_req_wr_n,
  input  logic              app_req_ack,
  input  logic              app_rd_valid,
  input  logic              app_last_rd,
  input  logic              app_wr_next_req,
  input  logic              app_last_wr,
  output logic [2:0]        grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA, ST_GUARD} state_t;

  state_t         state;
  logic [3:0]     guard_cnt;
  logic [2:0]     rr_ptr;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] own;
  logic           win_found;
  logic [2:0]     win_id;
  logic [AW-1:0]  win_addr;
  logic [LW-1:0]  win_len_raw;
  logic [LW-1:0]  win_len;
  int unsigned    cand;

  // Writes are held off while the post-read guard window is running.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++)
      elig[i] = ch_req[i] & ((state != ST_GUARD) | ch_wr_n[i]);
  end

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    if (elig[0]) begin
      win_found = 1'b1;
    end else begin
      // Round-robin rotates over 1..NCH-1 only; channel 0 never enters the ring.
      for (int unsigned k = 1; k < NCH; k++) begin
        if (RR != 0) begin
          cand = 32'(rr_ptr) + k;
          if (cand >= unsigned'(NCH)) cand = cand - unsigned'(NCH - 1);
        end else begin
          cand = k;
        end
        if (!win_found && elig[cand]) begin
          win_found = 1'b1;
          win_id    = 3'(cand);
        end
      end
    end
    win_addr    = ch_addr[32'(win_id)*AW +: AW];
    win_len_raw = ch_len[32'(win_id)*LW +: LW];
    win_len     = (win_len_raw == '0) ? LW'(1) : win_len_raw;
  end

  always_comb begin
    own = NCH'(1) << grant_id;
  end

  assign ch_ack      = (state == ST_REQ && app_req_ack) ? own : '0;
  assign ch_rd_valid = (state == ST_DATA && app_req_wr_n && app_rd_valid) ? own : '0;
  assign ch_wr_next  = (state == ST_DATA && !app_req_wr_n && app_wr_next_req) ? own : '0;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      guard_cnt    <= '0;
      rr_ptr       <= 3'(NCH - 1);
      grant_id     <= '0;
      app_req      <= 1'b0;
      app_req_addr <= '0;
      app_req_len  <= '0;
      app_req_wr_n <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_GUARD: begin
          if (win_found) begin
            state        <= ST_REQ;
            grant_id     <= win_id;
            app_req      <= 1'b1;
            app_req_addr <= win_addr;
            app_req_len  <= win_len;
            app_req_wr_n <= ch_wr_n[win_id];
          end else if (state == ST_GUARD) begin
            if (guard_cnt <= 4'd1) begin
              state     <= ST_IDLE;
              guard_cnt <= '0;
            end else begin
              guard_cnt <= guard_cnt - 4'd1;
            end
          end
        end
        ST_REQ: begin
          if (app_req_ack) begin
            app_req <= 1'b0;
            state   <= ST_DATA;
            if (RR != 0 && grant_id != 3'd0) rr_ptr <= grant_id;
          end
        end
        ST_DATA: begin
          if (app_req_wr_n && app_rd_valid && app_last_rd) begin
            if (GUARD > 0) begin
              state     <= ST_GUARD;
              guard_cnt <= 4'(GUARD);
            end else begin
              state <= ST_IDLE;
            end
          end else if (!app_req_wr_n && app_wr_next_req && app_last_wr) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
